// File: rtl/eight_data_cpr_pkg.sv
// Shared definitions for the eight-word compress/decompress block format:
// fixed geometry, per-word tag coding and the decompressor FSM states.
package eight_data_cpr_pkg;

    localparam int WORDS  = 8;
    localparam int WORD_W = 32;
    localparam int TAG_W  = 2;

    localparam logic [TAG_W-1:0] TAG_ZERO = 2'b00;  // word is zero, no bytes
    localparam logic [TAG_W-1:0] TAG_B1   = 2'b01;  // one byte, zero-extended
    localparam logic [TAG_W-1:0] TAG_B2   = 2'b10;  // two bytes, zero-extended
    localparam logic [TAG_W-1:0] TAG_W4   = 2'b11;  // full word verbatim

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Number of compressed bytes a tag occupies in the packed stream.
    function automatic logic [2:0] tag_bytes(input logic [TAG_W-1:0] tag);
        case (tag)
            TAG_ZERO: return 3'd0;
            TAG_B1:   return 3'd1;
            TAG_B2:   return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/cpr_word_extract.sv
// Rebuilds one 32-bit word from the low bytes of the compressed stream
// according to its tag, and reports how many bytes that word consumed.
module cpr_word_extract
    import eight_data_cpr_pkg::*;
(
    input  logic [WORD_W-1:0] win_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic [WORD_W-1:0] word_o,
    output logic [2:0]        size_o
);

    // Zero-extend the low 0/1/2/4 bytes depending on the tag.
    always_comb begin
        size_o = tag_bytes(tag_i);
        case (tag_i)
            TAG_ZERO: word_o = '0;
            TAG_B1:   word_o = {24'b0, win_i[7:0]};
            TAG_B2:   word_o = {16'b0, win_i[15:0]};
            default:  word_o = win_i;
        endcase
    end

endmodule

// File: rtl/eight_data_decompress_unit.sv
// Eight-word block decompressor: captures a packed block, expands one word
// per cycle by shifting consumed bytes out of a 256-bit register, then
// holds the result with a length-consistency flag until downstream accepts.
module eight_data_decompress_unit
    import eight_data_cpr_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      validIn,
    output logic                      readyOut,
    input  logic [WORDS*WORD_W-1:0]   cprDataIn,
    input  logic [WORDS*TAG_W-1:0]    tagIn,
    input  logic [7:0]                lenIn,
    output logic [WORDS*WORD_W-1:0]   dataOut,
    output logic [WORDS*TAG_W-1:0]    tagOut,
    output logic                      errOut,
    output logic                      validOut,
    input  logic                      readyIn
);

    state_e                     state_q, state_d;
    logic [WORDS*WORD_W-1:0]    sreg_q, sreg_d;
    logic [WORDS*WORD_W-1:0]    data_q, data_d;
    logic [WORDS*TAG_W-1:0]     tag_q, tag_d;
    logic [7:0]                 len_q, len_d;
    logic [2:0]                 idx_q, idx_d;
    logic [5:0]                 bcnt_q, bcnt_d;

    logic [TAG_W-1:0]           cur_tag;
    logic [WORD_W-1:0]          ext_word;
    logic [2:0]                 ext_size;

    assign cur_tag = tag_q[{idx_q, 1'b0} +: TAG_W];

    cpr_word_extract u_extract (
        .win_i  (sreg_q[WORD_W-1:0]),
        .tag_i  (cur_tag),
        .word_o (ext_word),
        .size_o (ext_size)
    );

    // State register; reset returns to IDLE and discards any partial block.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: accept in IDLE, eight decode cycles, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (validIn)        state_d = ST_DECODE;
            ST_DECODE: if (idx_q == 3'd7)  state_d = ST_DONE;
            ST_DONE:   if (readyIn)        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Handshake and error outputs decoded from state; the error compare is
    // widened so any claimed length above 32 can never match.
    always_comb begin
        readyOut = (state_q == ST_IDLE);
        validOut = (state_q == ST_DONE);
        errOut   = validOut && ({2'b00, bcnt_q} != len_q);
    end

    // Datapath next-state: capture on accept, one word per DECODE cycle.
    always_comb begin
        sreg_d = sreg_q;
        data_d = data_q;
        tag_d  = tag_q;
        len_d  = len_q;
        idx_d  = idx_q;
        bcnt_d = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (validIn) begin
                    sreg_d = cprDataIn;
                    tag_d  = tagIn;
                    len_d  = lenIn;
                    data_d = '0;
                    idx_d  = '0;
                    bcnt_d = '0;
                end
            end
            ST_DECODE: begin
                data_d[{idx_q, 5'b0} +: WORD_W] = ext_word;
                sreg_d = sreg_q >> {ext_size, 3'b000};
                bcnt_d = bcnt_q + {3'b000, ext_size};
                idx_d  = idx_q + 3'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            data_q <= data_d;
            tag_q  <= tag_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign dataOut = data_q;
    assign tagOut  = tag_q;

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed bench for the eight-word decompressor with a byte-pointer model
// of the block format and a per-cycle output compare.
module tb_eight_data_decompress_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         validIn;
    logic         readyOut;
    logic [255:0] cprDataIn;
    logic [15:0]  tagIn;
    logic [7:0]   lenIn;
    logic [255:0] dataOut;
    logic [15:0]  tagOut;
    logic         errOut;
    logic         validOut;
    logic         readyIn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] d;
        logic [15:0]  t;
        logic         e;
    } exp_t;
    exp_t expq[$];

    eight_data_decompress_unit dut (
        .clk       (clk),
        .reset     (reset),
        .validIn   (validIn),
        .readyOut  (readyOut),
        .cprDataIn (cprDataIn),
        .tagIn     (tagIn),
        .lenIn     (lenIn),
        .dataOut   (dataOut),
        .tagOut    (tagOut),
        .errOut    (errOut),
        .validOut  (validOut),
        .readyIn   (readyIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Format model: walk a byte pointer through the packed stream.
    function automatic void model(input logic [255:0] d, input logic [15:0] t,
                                  input logic [7:0] l, output logic [255:0] w,
                                  output logic e);
        int p;
        int n;
        p = 0;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            case (t[2*i +: 2])
                2'd0:    n = 0;
                2'd1:    n = 1;
                2'd2:    n = 2;
                default: n = 4;
            endcase
            for (int b = 0; b < n; b++)
                w[32*i + 8*b +: 8] = d[8*(p+b) +: 8];
            p += n;
        end
        e = (p != int'(l));
    endfunction

    // Per-cycle compare against the oldest outstanding expected block.
    always @(negedge clk) begin
        if (!reset) begin
            expq.delete();
        end else if (validOut) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cmp_unexpected_valid: got validOut=1 want 0 (no block pending)");
            end else begin
                chk("cmp_data", dataOut, expq[0].d);
                chk("cmp_tag", {240'b0, tagOut}, {240'b0, expq[0].t});
                chk("cmp_err", {255'b0, errOut}, {255'b0, expq[0].e});
                if (readyIn) void'(expq.pop_front());
            end
        end
    end

    // Offer a block, waiting (bounded) for readyOut; returns #1 after accept edge.
    task automatic accept(input logic [255:0] d, input logic [15:0] t, input logic [7:0] l);
        int   n;
        exp_t x;
        n = 0;
        while (!readyOut && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!readyOut) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got readyOut=0 want 1");
        end
        model(d, t, l, x.d, x.e);
        x.t = t;
        expq.push_back(x);
        validIn = 1'b1; cprDataIn = d; tagIn = t; lenIn = l;
        @(posedge clk); #1;
        validIn = 1'b0;
    endtask

    // From #1 after the accept edge: validOut low after k+7, high after k+8.
    task automatic wait_done(input string nm);
        repeat (7) begin @(posedge clk); #1; end
        chk({nm, "_valid_k7"}, {255'b0, validOut}, 256'd0);
        @(posedge clk); #1;
        chk({nm, "_valid_k8"}, {255'b0, validOut}, 256'd1);
    endtask

    task automatic take(input string nm);
        readyIn = 1'b1;
        @(posedge clk); #1;
        readyIn = 1'b0;
        chk({nm, "_readyOut_after"}, {255'b0, readyOut}, 256'd1);
        chk({nm, "_valid_after"}, {255'b0, validOut}, 256'd0);
    endtask

    logic [255:0] d_all, d_rnd, d_mix, exp_mix, w, held;
    logic         e;

    initial begin
        reset = 1'b0; validIn = 1'b1; readyIn = 1'b0;
        cprDataIn = '1; tagIn = '1; lenIn = 8'd32;
        d_all   = 256'h4321FEDC_BA987654_3210FEDC_BA987654_3210FEDC_BA987654_3210FEDC_87654321;
        for (int i = 0; i < 8; i++) d_rnd[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) d_mix[32*i +: 32] = $urandom;
        d_mix[79:0] = 80'h5432_1FED_CBA9_8765_4321;
        exp_mix = {32'h0, 32'h5432, 32'h1F, 32'h0, 32'hEDCBA987, 32'h6543, 32'h0, 32'h21};

        // Pin the model on the mixed block and on length errors.
        model(d_mix, 16'h24E1, 8'h0A, w, e);
        chk("model_mix_words", w, exp_mix);
        chk("model_mix_err", {255'b0, e}, 256'd0);
        model(d_mix, 16'h24E1, 8'h40, w, e);
        chk("model_len40_err", {255'b0, e}, 256'd1);

        // Reset with validIn asserted must not capture anything.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; validIn = 1'b0;
        chk("rst_valid", {255'b0, validOut}, 256'd0);
        chk("rst_err", {255'b0, errOut}, 256'd0);
        chk("rst_data", dataOut, 256'd0);
        chk("rst_tag", {240'b0, tagOut}, 256'd0);
        chk("rst_ready", {255'b0, readyOut}, 256'd1);

        // All full words: output equals input.
        accept(d_all, 16'hFFFF, 8'h20);
        wait_done("all11");
        chk("all11_data", dataOut, d_all);
        chk("all11_err", {255'b0, errOut}, 256'd0);
        take("all11");

        // All zero words.
        accept(d_rnd, 16'h0000, 8'h00);
        wait_done("all00");
        chk("all00_data", dataOut, 256'd0);
        chk("all00_err", {255'b0, errOut}, 256'd0);
        take("all00");

        // Mixed block, correct and wrong lengths.
        accept(d_mix, 16'h24E1, 8'h0A);
        wait_done("mix0a");
        chk("mix0a_data", dataOut, exp_mix);
        chk("mix0a_err", {255'b0, errOut}, 256'd0);
        take("mix0a");

        accept(d_mix, 16'h24E1, 8'h0B);
        wait_done("mix0b");
        chk("mix0b_data", dataOut, exp_mix);
        chk("mix0b_err", {255'b0, errOut}, 256'd1);
        take("mix0b");

        accept(d_mix, 16'h24E1, 8'h40);
        wait_done("mix40");
        chk("mix40_err", {255'b0, errOut}, 256'd1);

        // Backpressure: hold in DONE while validIn pulses with other data.
        held = dataOut;
        for (int i = 0; i < 5; i++) begin
            validIn = (i % 2 == 0); cprDataIn = d_all; tagIn = 16'hFFFF; lenIn = 8'h20;
            @(posedge clk); #1;
            chk("bp_ready", {255'b0, readyOut}, 256'd0);
            chk("bp_valid", {255'b0, validOut}, 256'd1);
            chk("bp_data", dataOut, held);
        end
        validIn = 1'b0;
        take("bp");
        // Back-to-back block right after the transfer.
        accept(d_all, 16'hFFFF, 8'h20);
        wait_done("b2b");
        chk("b2b_data", dataOut, d_all);
        take("b2b");

        // Reset during the 4th DECODE cycle aborts the block.
        accept(d_mix, 16'h24E1, 8'h0A);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", {255'b0, validOut}, 256'd0);
        chk("abort_data", dataOut, 256'd0);
        chk("abort_ready", {255'b0, readyOut}, 256'd1);
        reset = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("abort_no_output", {255'b0, validOut}, 256'd0);

        // Recovery after the abort.
        accept(d_mix, 16'h24E1, 8'h0A);
        wait_done("recov");
        chk("recov_data", dataOut, exp_mix);
        take("recov");

        chk("queue_drained", 256'(expq.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
